// File: rtl/sca_trigger_pkg.sv
// Shared types and default widths for the SCA capture trigger conditioner.
package sca_trigger_pkg;

    localparam int unsigned DefDelayW = 8;
    localparam int unsigned DefWidthW = 16;
    localparam int unsigned DefCntW   = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_DELAY   = 3'd2,
        ST_ACTIVE  = 3'd3,
        ST_HOLDOFF = 3'd4
    } sca_trig_state_e;

endpackage

// File: rtl/sca_trigger_cnt.sv
// Loadable down-counter; stops at zero and flags it.
module sca_trigger_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sca_capture_trigger.sv
// Conditions the software SCA trigger: gated by AES busy, delayed, width-shaped,
// one trigger per software assertion, with a saturating fire counter and miss flag.
module sca_capture_trigger
    import sca_trigger_pkg::*;
#(
    parameter int unsigned DelayW = DefDelayW,
    parameter int unsigned WidthW = DefWidthW,
    parameter int unsigned CntW   = DefCntW
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              sw_trig_i,
    input  logic              busy_i,
    input  logic [DelayW-1:0] delay_i,
    input  logic [WidthW-1:0] width_i,
    input  logic              cnt_clr_i,
    output logic              trig_o,
    output logic [CntW-1:0]   fire_cnt_o,
    output logic              miss_o
);

    sca_trig_state_e   state_q, state_d;
    logic              sw_q, sw_d;
    logic [DelayW-1:0] dly_q, dly_d;
    logic [WidthW-1:0] wid_q, wid_d;
    logic              trig_q, trig_d;
    logic [CntW-1:0]   fire_cnt_q, fire_cnt_d;
    logic              miss_q, miss_d;

    logic sw_rise;
    logic latch_cfg, dly_load, dly_dec, dly_zero, wid_load, wid_dec, wid_zero;
    logic fire_inc, miss_set;

    assign sw_rise = sw_trig_i & ~sw_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (sw_rise) state_d = ST_ARMED;
            ST_ARMED: begin
                if (!sw_trig_i) begin
                    state_d = ST_HOLDOFF;
                end else if (busy_i) begin
                    state_d = (dly_q == '0) ? ST_ACTIVE : ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (!busy_i) state_d = ST_HOLDOFF;
                else if (dly_zero) state_d = ST_ACTIVE;
            end
            // Programmed width is unconditional; zero width tracks busy & sw.
            ST_ACTIVE: begin
                if (wid_q != '0) begin
                    if (wid_zero) state_d = ST_HOLDOFF;
                end else if (!(busy_i && sw_trig_i)) begin
                    state_d = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: if (!sw_trig_i) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        latch_cfg = (state_q == ST_IDLE) && sw_rise;
        dly_load  = (state_q == ST_ARMED) && sw_trig_i && busy_i && (dly_q != '0);
        dly_dec   = (state_q == ST_DELAY) && busy_i && !dly_zero;
        wid_load  = (state_d == ST_ACTIVE) && (state_q != ST_ACTIVE);
        wid_dec   = (state_q == ST_ACTIVE) && !wid_zero;
        fire_inc  = wid_load;
        miss_set  = ((state_q == ST_ARMED) && !sw_trig_i) ||
                    ((state_q == ST_DELAY) && !busy_i);
        trig_d    = (state_d == ST_ACTIVE);
    end

    always_comb begin
        sw_d  = sw_trig_i;
        dly_d = latch_cfg ? delay_i : dly_q;
        wid_d = latch_cfg ? width_i : wid_q;
        fire_cnt_d = fire_cnt_q;
        miss_d     = miss_q | miss_set;
        if (cnt_clr_i) begin
            fire_cnt_d = '0;
            miss_d     = 1'b0;
        end else if (fire_inc && (fire_cnt_q != '1)) begin
            fire_cnt_d = fire_cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sw_q       <= 1'b0;
            dly_q      <= '0;
            wid_q      <= '0;
            trig_q     <= 1'b0;
            fire_cnt_q <= '0;
            miss_q     <= 1'b0;
        end else begin
            sw_q       <= sw_d;
            dly_q      <= dly_d;
            wid_q      <= wid_d;
            trig_q     <= trig_d;
            fire_cnt_q <= fire_cnt_d;
            miss_q     <= miss_d;
        end
    end

    sca_trigger_cnt #(.W(DelayW)) u_dly_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (dly_load),
        .load_val_i (dly_q - DelayW'(1)),
        .dec_i      (dly_dec),
        .zero_o     (dly_zero)
    );

    sca_trigger_cnt #(.W(WidthW)) u_wid_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (wid_load),
        .load_val_i (wid_q - WidthW'(1)),
        .dec_i      (wid_dec),
        .zero_o     (wid_zero)
    );

    assign trig_o     = trig_q;
    assign fire_cnt_o = fire_cnt_q;
    assign miss_o     = miss_q;

endmodule
